image_scan_ctrl: RTL and testbench

IMAGE_SCAN_CTRL -- requirements
Module: image_scan_ctrl

---
 rtl/image_scan_ctrl.sv | 95 +++++++++
 tb/tb_image_scan_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/image_scan_ctrl.sv
// image_scan_ctrl: raster-scans an image store and streams registered pixels over valid/ready
module image_scan_ctrl #(
    parameter int unsigned MAX_WIDTH  = 1080,
    parameter int unsigned MAX_HEIGHT = 1080
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [11:0] WIDTH,
    input  logic [11:0] HEIGHT,
    output logic [11:0] ROW,
    output logic [11:0] COL,
    input  logic [7:0]  RED_IN,
    input  logic [7:0]  GREEN_IN,
    input  logic [7:0]  BLUE_IN,
    output logic [7:0]  PIX_R,
    output logic [7:0]  PIX_G,
    output logic [7:0]  PIX_B,
    output logic        PIX_VALID,
    input  logic        PIX_READY,
    output logic        SOF,
    output logic        EOL,
    output logic        EOF,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [15:0] FRAME_CNT
);
    typedef enum logic [1:0] {IDLE, FETCH, SEND, FIN} state_t;

    state_t state, state_next;
    logic [11:0] w, h;
    logic last_col, last_row, bad_dims;

    assign last_col  = COL == w - 12'd1;
    assign last_row  = ROW == h - 12'd1;
    assign bad_dims  = WIDTH == '0 || HEIGHT == '0 || 32'(WIDTH) > MAX_WIDTH || 32'(HEIGHT) > MAX_HEIGHT;
    assign PIX_VALID = state == SEND;
    assign BUSY      = state != IDLE;
    assign DONE      = state == FIN;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  state_next = START && !bad_dims ? FETCH : IDLE;
            FETCH: state_next = SEND;
            SEND:  state_next = !PIX_READY ? SEND : last_col && last_row ? FIN : FETCH;
            FIN:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            w         <= '0;
            h         <= '0;
            ROW       <= '0;
            COL       <= '0;
            PIX_R     <= '0;
            PIX_G     <= '0;
            PIX_B     <= '0;
            SOF       <= 1'b0;
            EOL       <= 1'b0;
            EOF       <= 1'b0;
            ERR       <= 1'b0;
            FRAME_CNT <= '0;
        end else begin
            state <= state_next;
            ERR   <= state == IDLE && START && bad_dims;
            case (state)
                IDLE: if (START) begin
                    w   <= WIDTH;
                    h   <= HEIGHT;
                    ROW <= '0;
                    COL <= '0;
                end
                FETCH: begin
                    PIX_R <= RED_IN;
                    PIX_G <= GREEN_IN;
                    PIX_B <= BLUE_IN;
                    SOF   <= ROW == '0 && COL == '0;
                    EOL   <= last_col;
                    EOF   <= last_col && last_row;
                end
                // the last handshake also parks the address at the origin for FIN
                SEND: if (PIX_READY) begin
                    COL <= last_col ? '0 : COL + 12'd1;
                    ROW <= last_col && last_row ? '0 : last_col ? ROW + 12'd1 : ROW;
                    if (last_col && last_row) FRAME_CNT <= FRAME_CNT + 16'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_image_scan_ctrl.sv
// tb_image_scan_ctrl: randomized frames checked against a per-pixel raster model of the scan
module tb_image_scan_ctrl;
    localparam int MW = 16;
    localparam int MH = 12;

    logic        CLK = 1'b0, RESET = 1'b1, START = 1'b0, PIX_READY = 1'b0;
    logic [11:0] WIDTH = '0, HEIGHT = '0, ROW, COL;
    logic [7:0]  RED_IN, GREEN_IN, BLUE_IN, PIX_R, PIX_G, PIX_B;
    logic        PIX_VALID, SOF, EOL, EOF, BUSY, DONE, ERR;
    logic [15:0] FRAME_CNT;
    logic [23:0] seed = '0;
    int errors = 0, checks = 0, exp_frames = 0;

    image_scan_ctrl #(.MAX_WIDTH(MW), .MAX_HEIGHT(MH)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .WIDTH(WIDTH), .HEIGHT(HEIGHT),
        .ROW(ROW), .COL(COL), .RED_IN(RED_IN), .GREEN_IN(GREEN_IN), .BLUE_IN(BLUE_IN),
        .PIX_R(PIX_R), .PIX_G(PIX_G), .PIX_B(PIX_B), .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY),
        .SOF(SOF), .EOL(EOL), .EOF(EOF), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .FRAME_CNT(FRAME_CNT)
    );

    always #5 CLK = ~CLK;

    // image store contents: a seeded pattern of the pixel coordinates
    function automatic logic [23:0] pix(input logic [11:0] r, input logic [11:0] c, input logic [23:0] s);
        return {r[7:0] ^ s[7:0], c[7:0] + s[15:8], r[7:0] + c[7:0] + s[23:16]};
    endfunction

    assign {RED_IN, GREEN_IN, BLUE_IN} = pix(ROW, COL, seed);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic run_bad(input int w, input int h);
        WIDTH  = 12'(w);
        HEIGHT = 12'(h);
        START  = 1'b1;
        tick();
        START = 1'b0;
        check("err_pulse", {ERR, BUSY, PIX_VALID}, 3'b100);
        tick();
        check("err_clear", {ERR, BUSY, PIX_VALID, DONE}, 4'b0000);
    endtask

    // stall_k/stall_n: hold PIX_READY low for stall_n cycles on pixel stall_k;
    // rnd: random backpressure; perturb: junk START/WIDTH/HEIGHT mid-frame; abort_k: reset in SEND of that pixel
    task automatic run_frame(input int w, input int h, input int stall_k, input int stall_n,
                             input bit rnd, input bit perturb, input int abort_k);
        int r, c, s;
        bit rdy;
        seed   = 24'($urandom);
        WIDTH  = 12'(w);
        HEIGHT = 12'(h);
        START  = 1'b1;
        tick();
        START = 1'b0;
        for (int k = 0; k < w * h; k++) begin
            r = k / w;
            c = k % w;
            check("fetch_state", {PIX_VALID, BUSY, DONE}, 3'b010);
            PIX_READY = 1'($urandom_range(0, 1));
            if (perturb) begin
                START  = 1'($urandom_range(0, 1));
                WIDTH  = 12'($urandom_range(1, MW));
                HEIGHT = 12'($urandom_range(1, MH));
            end
            tick();
            s = 0;
            do begin
                check("send_valid", PIX_VALID, 1);
                check("send_addr", {ROW, COL}, {12'(r), 12'(c)});
                check("send_data", {PIX_R, PIX_G, PIX_B}, pix(12'(r), 12'(c), seed));
                check("send_side", {SOF, EOL, EOF}, {k == 0, c == w - 1, k == w * h - 1});
                check("send_flags", {BUSY, DONE, ERR}, 3'b100);
                if (k == abort_k) begin
                    RESET = 1'b1;
                    tick();
                    RESET = 1'b0;
                    exp_frames = 0;
                    check("abort_addr_pix", {ROW, COL, PIX_R, PIX_G, PIX_B}, 0);
                    check("abort_flags", {PIX_VALID, SOF, EOL, EOF, BUSY, DONE, ERR, FRAME_CNT}, 0);
                    return;
                end
                rdy = k == stall_k ? s >= stall_n : rnd ? (s >= 3 || $urandom_range(0, 1) == 1) : 1'b1;
                PIX_READY = rdy;
                if (perturb) begin
                    START = 1'($urandom_range(0, 1));
                    WIDTH = 12'($urandom_range(1, MW));
                end
                tick();
                s++;
            end while (!rdy);
        end
        START = 1'b0;
        PIX_READY = 1'b0;
        check("done_pulse", {DONE, PIX_VALID, BUSY}, 3'b101);
        tick();
        exp_frames++;
        check("idle_after", {DONE, BUSY, PIX_VALID}, 3'b000);
        check("frame_cnt", FRAME_CNT, 64'(16'(exp_frames)));
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_addr_pix", {ROW, COL, PIX_R, PIX_G, PIX_B}, 0);
        check("rst_flags", {PIX_VALID, SOF, EOL, EOF, BUSY, DONE, ERR, FRAME_CNT}, 0);
        RESET = 1'b0;
        tick();
        run_frame(2, 2, -1, 0, 1'b0, 1'b0, -1);
        run_frame(2, 2, 1, 5, 1'b0, 1'b0, -1);
        run_bad(0, 2);
        run_bad(MW + 1, 2);
        run_bad(3, 0);
        run_bad(3, MH + 1);
        run_frame(3, 2, -1, 0, 1'b1, 1'b1, -1);
        run_frame(3, 2, -1, 0, 1'b1, 1'b0, 2);
        run_frame(3, 2, -1, 0, 1'b1, 1'b0, -1);
        run_frame(1, 1, -1, 0, 1'b0, 1'b0, -1);
        run_frame(MW, 1, -1, 0, 1'b1, 1'b0, -1);
        run_frame(1, MH, -1, 0, 1'b1, 1'b0, -1);
        for (int i = 0; i < 6; i++)
            run_frame(int'($urandom_range(1, 6)), int'($urandom_range(1, 4)), -1, 0, 1'b1, 1'($urandom_range(0, 1)), -1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
